// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and frame constants.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam int DATA_BITS            = 8;
    localparam int DEFAULT_CLK_FREQ     = 100_000_000;
    localparam int DEFAULT_BAUD         = 9600;
    localparam int DEFAULT_CLKS_PER_BIT = DEFAULT_CLK_FREQ / DEFAULT_BAUD;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled, one-cycle tick on wrap.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic bit_tick
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Held at zero while disabled so every bit period starts from a clean count.
    always_comb begin
        cnt_d = cnt_q;
        if (!en)
            cnt_d = '0;
        else if (cnt_q == LAST)
            cnt_d = '0;
        else
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign bit_tick = en && (cnt_q == LAST);

endmodule

// File: rtl/uart_byte_tx.sv
// 8N1 byte transmitter with valid/ready handshake; txd and transmit_ready are registered.
module uart_byte_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ     = DEFAULT_CLK_FREQ,
    parameter int BAUD         = DEFAULT_BAUD,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] word,
    input  logic       send,
    output logic       transmit_ready,
    output logic       txd,
    output logic       busy
);

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    tx_state_t  state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic       txd_q, txd_d;
    logic       ready_q, ready_d;
    logic       bit_tick;

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk     (clk),
        .rst     (rst),
        .en      (state_q != IDLE),
        .bit_tick(bit_tick)
    );

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        txd_d     = txd_q;
        ready_d   = ready_q;
        case (state_q)
            IDLE: begin
                if (send && ready_q) begin
                    state_d   = START;
                    shift_d   = word;
                    bit_idx_d = '0;
                    txd_d     = 1'b0;
                    ready_d   = 1'b0;
                end
            end
            START: begin
                if (bit_tick) begin
                    state_d   = DATA;
                    bit_idx_d = '0;
                    txd_d     = shift_q[0];
                end
            end
            DATA: begin
                if (bit_tick) begin
                    if (bit_idx_q == LAST_BIT) begin
                        state_d = STOP;
                        txd_d   = 1'b1;
                    end else begin
                        // Next bit is presented together with the shift, keeping txd registered.
                        shift_d   = shift_q >> 1;
                        txd_d     = shift_q[1];
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            STOP: begin
                if (bit_tick) begin
                    state_d = IDLE;
                    ready_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                txd_d   = 1'b1;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            shift_q   <= 8'h00;
            bit_idx_q <= '0;
            txd_q     <= 1'b1;
            ready_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            txd_q     <= txd_d;
            ready_q   <= ready_d;
        end
    end

    assign txd            = txd_q;
    assign transmit_ready = ready_q;
    assign busy           = (state_q != IDLE);

endmodule
